// File: rtl/debounce_filter.sv
`timescale 1ns/1ps
// Per-channel debouncer for already-synchronized slow inputs: a new level is
// accepted after STABLE_TICKS consecutive qualifying ticks, with one-cycle rise/fall strobes.
module debounce_filter #(
    parameter int   WIDTH        = 1,
    parameter int   STABLE_TICKS = 50000,
    parameter logic DEFAULT      = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] x,
    input  logic             tick,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int            CW   = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          lvl;
        logic          rise_q;
        logic          fall_q;

        // Any cycle where the input agrees with the level restarts qualification,
        // whether or not tick is present.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt    <= '0;
                lvl    <= DEFAULT;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (x[i] == lvl) begin
                    cnt <= '0;
                end else if (tick) begin
                    if (cnt == LAST) begin
                        lvl    <= x[i];
                        cnt    <= '0;
                        rise_q <= x[i];
                        fall_q <= ~x[i];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end

        assign level[i] = lvl;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
    end

endmodule

// File: tb/tb_debounce_filter.sv
`timescale 1ns/1ps
// Bench for debounce_filter: three instances (2ch/4 ticks, 1ch/3 ticks, 2ch/1 tick)
// exercised by directed scenarios and a randomized run against a run-length model.
module tb_debounce_filter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] x_a = 2'b00;
    logic       tick_a = 1'b1;
    logic [1:0] level_a, rise_a, fall_a;
    logic       x_b = 1'b0;
    logic       tick_b = 1'b1;
    logic       level_b, rise_b, fall_b;
    logic [1:0] x_c = 2'b00;
    logic       tick_c = 1'b1;
    logic [1:0] level_c, rise_c, fall_c;

    int checks = 0;
    int failures = 0;

    // model state: accepted level and length of the current ticked mismatch run
    int         nt [3] = '{4, 3, 1};
    int         wd [3] = '{2, 1, 2};
    logic [1:0] mlev [3];
    logic [1:0] mr [3];
    logic [1:0] mf [3];
    int         mrun [3][2];
    logic [14:0] exp_q[$];

    always #5 clk = ~clk;

    debounce_filter #(.WIDTH(2), .STABLE_TICKS(4), .DEFAULT(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .x(x_a), .tick(tick_a),
        .level(level_a), .rise(rise_a), .fall(fall_a));

    debounce_filter #(.WIDTH(1), .STABLE_TICKS(3), .DEFAULT(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .x(x_b), .tick(tick_b),
        .level(level_b), .rise(rise_b), .fall(fall_b));

    debounce_filter #(.WIDTH(2), .STABLE_TICKS(1), .DEFAULT(1'b0)) dut_c (
        .clk(clk), .reset_n(reset_n), .x(x_c), .tick(tick_c),
        .level(level_c), .rise(rise_c), .fall(fall_c));

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mlev[d] = 2'b00;
            mr[d]   = 2'b00;
            mf[d]   = 2'b00;
            for (int c = 0; c < 2; c++) mrun[d][c] = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [1:0] xv, input logic tk);
        mr[d] = 2'b00;
        mf[d] = 2'b00;
        for (int c = 0; c < wd[d]; c++) begin
            if (xv[c] == mlev[d][c]) begin
                mrun[d][c] = 0;
            end else if (tk) begin
                mrun[d][c] = mrun[d][c] + 1;
                if (mrun[d][c] == nt[d]) begin
                    mlev[d][c] = xv[c];
                    if (xv[c]) mr[d][c] = 1'b1;
                    else       mf[d][c] = 1'b1;
                    mrun[d][c] = 0;
                end
            end
        end
    endtask

    // one clock edge; returns 1 ns after it with the models updated
    task automatic tick_clk();
        @(posedge clk);
        model_step(0, x_a, tick_a);
        model_step(1, {1'b0, x_b}, tick_b);
        model_step(2, x_c, tick_c);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        x_a = 2'b11;
        #3;
        checks++;
        if ({level_a, rise_a, fall_a} !== 6'b0) begin
            failures++;
            $display("FAIL reset_a_during got=%b exp=000000", {level_a, rise_a, fall_a});
        end
        checks++;
        if ({level_b, rise_b, fall_b, level_c, rise_c, fall_c} !== 9'b0) begin
            failures++;
            $display("FAIL reset_bc_during got=%b exp=0", {level_b, rise_b, fall_b, level_c, rise_c, fall_c});
        end
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (level_a !== 2'b00) begin
            failures++;
            $display("FAIL reset_a_held got=%b exp=00", level_a);
        end
        reset_n = 1'b1;
        model_reset();
        for (int e = 1; e <= 5; e++) begin
            tick_clk();
            checks++;
            if (level_a !== ((e >= 4) ? 2'b11 : 2'b00) || rise_a !== ((e == 4) ? 2'b11 : 2'b00)
                || fall_a !== 2'b00) begin
                failures++;
                $display("FAIL reset_release edge=%0d got lvl=%b r=%b f=%b", e, level_a, rise_a, fall_a);
            end
        end
    endtask

    task automatic test_release();
        x_a = 2'b00;
        for (int e = 1; e <= 5; e++) begin
            tick_clk();
            checks++;
            if (level_a !== ((e >= 4) ? 2'b00 : 2'b11) || fall_a !== ((e == 4) ? 2'b11 : 2'b00)
                || rise_a !== 2'b00) begin
                failures++;
                $display("FAIL release edge=%0d got lvl=%b r=%b f=%b", e, level_a, rise_a, fall_a);
            end
        end
    endtask

    task automatic test_press();
        x_a = 2'b01;
        for (int e = 1; e <= 5; e++) begin
            tick_clk();
            checks++;
            if (level_a !== ((e >= 4) ? 2'b01 : 2'b00) || rise_a !== ((e == 4) ? 2'b01 : 2'b00)
                || fall_a !== 2'b00) begin
                failures++;
                $display("FAIL press edge=%0d got lvl=%b r=%b f=%b", e, level_a, rise_a, fall_a);
            end
        end
    endtask

    task automatic test_bounce();
        logic [9:0] pat;
        int pulses;
        pat = 10'b1111110111;
        pulses = 0;
        x_a = 2'b00;
        repeat (4) tick_clk();
        for (int k = 0; k < 10; k++) begin
            x_a = {1'b0, pat[k]};
            tick_clk();
            if (rise_a[0]) pulses++;
            checks++;
            if (level_a[0] !== (k >= 7) || rise_a[0] !== (k == 7) || fall_a[0] !== 1'b0) begin
                failures++;
                $display("FAIL bounce k=%0d got lvl=%b r=%b f=%b", k, level_a[0], rise_a[0], fall_a[0]);
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL bounce_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_tick_gating();
        x_b = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick_b = (c % 4 == 3);
            tick_clk();
            checks++;
            if (level_b !== (c >= 11) || rise_b !== (c == 11) || fall_b !== 1'b0) begin
                failures++;
                $display("FAIL tick_gate c=%0d got lvl=%b r=%b f=%b", c, level_b, rise_b, fall_b);
            end
        end
        x_b = 1'b0;
        tick_b = 1'b1;
        repeat (3) tick_clk();
        checks++;
        if (level_b !== 1'b0 || fall_b !== 1'b1) begin
            failures++;
            $display("FAIL tick_gate_fall got lvl=%b f=%b exp lvl=0 f=1", level_b, fall_b);
        end
        for (int c = 0; c < 22; c++) begin
            tick_b = (c % 4 == 3);
            x_b = (c != 8);
            tick_clk();
            checks++;
            if (level_b !== (c >= 19) || rise_b !== (c == 19)) begin
                failures++;
                $display("FAIL tick_gate_restart c=%0d got lvl=%b r=%b", c, level_b, rise_b);
            end
        end
        tick_b = 1'b1;
    endtask

    task automatic test_mid_reset();
        do_reset();
        x_a = 2'b10;
        repeat (4) tick_clk();
        checks++;
        if (level_a !== 2'b10 || rise_a !== 2'b10) begin
            failures++;
            $display("FAIL mid_setup got lvl=%b r=%b exp lvl=10 r=10", level_a, rise_a);
        end
        x_a = 2'b11;
        repeat (2) tick_clk();
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({level_a, rise_a, fall_a} !== 6'b0) begin
            failures++;
            $display("FAIL mid_async_clear got=%b exp=000000", {level_a, rise_a, fall_a});
        end
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick_clk();
            checks++;
            if (level_a !== ((e >= 4) ? 2'b11 : 2'b00) || rise_a !== ((e == 4) ? 2'b11 : 2'b00)
                || fall_a !== 2'b00) begin
                failures++;
                $display("FAIL mid_requalify edge=%0d got lvl=%b r=%b f=%b", e, level_a, rise_a, fall_a);
            end
        end
    endtask

    task automatic test_stable1();
        logic [1:0] prev;
        logic [1:0] xv;
        prev = 2'b00;
        for (int k = 0; k < 40; k++) begin
            xv = 2'($urandom_range(0, 3));
            x_c = xv;
            tick_clk();
            checks++;
            if (level_c !== xv || rise_c !== (xv & ~prev) || fall_c !== (~xv & prev)) begin
                failures++;
                $display("FAIL stable1 k=%0d got lvl=%b r=%b f=%b exp lvl=%b r=%b f=%b",
                         k, level_c, rise_c, fall_c, xv, xv & ~prev, ~xv & prev);
            end
            prev = xv;
        end
        x_c = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp_v;
        logic [14:0] got_v;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 2) == 0) x_a = x_a ^ 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) x_b = ~x_b;
            x_c = 2'($urandom_range(0, 3));
            tick_a = ($urandom_range(0, 3) != 0);
            tick_b = ($urandom_range(0, 1) == 0);
            tick_clk();
            exp_q.push_back({mlev[0], mr[0], mf[0], mlev[1][0], mr[1][0], mf[1][0], mlev[2], mr[2], mf[2]});
            got_v = {level_a, rise_a, fall_a, level_b, rise_b, fall_b, level_c, rise_c, fall_c};
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL random k=%0d got=%b exp=%b", k, got_v, exp_v);
            end
            if ($urandom_range(0, 149) == 0) begin
                #1;
                reset_n = 1'b0;
                model_reset();
                #1;
                checks++;
                if ({level_a, rise_a, fall_a, level_b, rise_b, fall_b, level_c, rise_c, fall_c} !== 15'b0) begin
                    failures++;
                    $display("FAIL random_reset k=%0d got=%b exp=0", k,
                             {level_a, rise_a, fall_a, level_b, rise_b, fall_b, level_c, rise_c, fall_c});
                end
                @(posedge clk);
                #3;
                reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_release();
        test_press();
        test_bounce();
        test_tick_gating();
        test_mid_reset();
        test_stable1();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
